// File: rtl/arbiter_pkg.sv
// Shared types for the weighted round-robin stream arbiter.
package arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Rotating find-first: returns the first set request at or after i_start, wrapping modulo N.
module rr_priority_select #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned k;
      k = (32'(i_start) + i) % N;
      if (!o_found && i_req[IDX_W'(k)]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter_wrr.sv
// Packet-locked weighted round-robin arbiter merging INPUT_NUM valid/ready streams into one
// registered output; each input may win up to its weight in consecutive packets.
module stream_arbiter_wrr
  import arbiter_pkg::*;
#(
  parameter int unsigned INPUT_NUM  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WEIGHT_W   = 4
) (
  input  logic                                  ACLK,
  input  logic                                  ARESETn,
  input  logic [INPUT_NUM-1:0][DATA_WIDTH-1:0]  data_i,
  input  logic [INPUT_NUM-1:0]                  last_i,
  input  logic [INPUT_NUM-1:0]                  valid_i,
  output logic [INPUT_NUM-1:0]                  ready_o,
  input  logic [INPUT_NUM-1:0][WEIGHT_W-1:0]    weights_i,
  output logic [DATA_WIDTH-1:0]                 data_o,
  output logic                                  last_o,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [$clog2(INPUT_NUM)-1:0]          grant_o,
  output logic                                  busy_o
);

  localparam int unsigned IDX_W    = $clog2(INPUT_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_NUM - 1);

  arb_state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_grant, w_grant_nxt;
  logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
  logic [WEIGHT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                  r_turn_vld, w_turn_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last, r_valid;

  logic [IDX_W-1:0]      w_start, w_sel_idx;
  logic                  w_sel_found;
  logic [WEIGHT_W-1:0]   w_eff_w;
  logic                  w_keep, w_out_rdy, w_accept;

  // r_turn_vld clear means no input owns a turn yet, so the first decision searches from ptr+1.
  assign w_start   = (r_ptr == LAST_IDX) ? '0 : r_ptr + IDX_W'(1);
  assign w_eff_w   = (weights_i[r_ptr] == '0) ? WEIGHT_W'(1) : weights_i[r_ptr];
  assign w_keep    = r_turn_vld && valid_i[r_ptr] && (r_cnt < w_eff_w);
  assign w_out_rdy = !r_valid || ready_i;
  assign w_accept  = (r_state == ST_BUSY) && valid_i[r_grant] && w_out_rdy;

  rr_priority_select #(
    .N     (INPUT_NUM),
    .IDX_W (IDX_W)
  ) u_sel (
    .i_req   (valid_i),
    .i_start (w_start),
    .o_found (w_sel_found),
    .o_idx   (w_sel_idx)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_ptr      <= LAST_IDX;
      r_cnt      <= '0;
      r_turn_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_turn_vld <= w_turn_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_turn_nxt  = r_turn_vld;
    ready_o     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_found) begin
          w_state_nxt = ST_BUSY;
          if (w_keep) begin
            w_grant_nxt = r_ptr;
          end else begin
            w_grant_nxt = w_sel_idx;
            w_ptr_nxt   = w_sel_idx;
            w_cnt_nxt   = '0;
            w_turn_nxt  = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        ready_o[r_grant] = w_out_rdy;
        if (w_accept && last_i[r_grant]) begin
          w_state_nxt = ST_IDLE;
          if (r_cnt != '1) w_cnt_nxt = r_cnt + WEIGHT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Single-entry output register: loads on accept, drains when downstream is ready.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= data_i[r_grant];
      r_last  <= last_i[r_grant];
      r_valid <= 1'b1;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign data_o  = r_data;
  assign last_o  = r_last;
  assign valid_o = r_valid;
  assign grant_o = r_grant;
  assign busy_o  = (r_state == ST_BUSY);

endmodule

// File: tb/tb_stream_arbiter_wrr.sv
// Bench for stream_arbiter_wrr: directed scenarios plus randomized traffic against a
// transaction-level reference model with per-input packet sources and an output scoreboard.
module tb_stream_arbiter_wrr;

  logic            ACLK;
  logic            ARESETn;
  logic [4:0][15:0] data_i;
  logic [4:0]      last_i;
  logic [4:0]      valid_i;
  logic [4:0]      ready_o;
  logic [4:0][3:0] weights_i;
  logic [15:0]     data_o;
  logic            last_o;
  logic            valid_o;
  logic            ready_i;
  logic [2:0]      grant_o;
  logic            busy_o;

  stream_arbiter_wrr #(
    .INPUT_NUM  (5),
    .DATA_WIDTH (16),
    .WEIGHT_W   (4)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .data_i    (data_i),
    .last_i    (last_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .weights_i (weights_i),
    .data_o    (data_o),
    .last_o    (last_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .grant_o   (grant_o),
    .busy_o    (busy_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Packet sources: beat = {last, data}
  logic [16:0] mem [5][128];
  int          wr [5];
  int          rd [5];
  bit          gap;

  // Reference model state
  int          m_ptr, m_cnt, m_grant;
  bit          m_fresh, m_busy, m_vo;
  logic [16:0] sb_q[$];
  int          gseq[$];
  logic [16:0] dseq[$];
  bit          prev_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cdata(input int i);
    return 16'hEEEE - 16'(i) * 16'h1111;
  endfunction

  task automatic add_pkt(input int i, input int len, input bit rnd);
    for (int b = 0; b < len; b++) begin
      mem[i][wr[i]] = {(b == len - 1), rnd ? 16'($urandom) : cdata(i)};
      wr[i]++;
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < 5; i++) if (rd[i] < wr[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < 5; i++) begin
      bit has;
      has = rd[i] < wr[i];
      valid_i[3'(i)] = has && (!gap || $urandom_range(0, 3) != 0);
      data_i[3'(i)]  = has ? mem[i][rd[i]][15:0] : 16'h0;
      last_i[3'(i)]  = has ? mem[i][rd[i]][16] : 1'b0;
    end
  endtask

  // Weighted round-robin decision from the rules: stay on ptr while it has turns left,
  // otherwise take the next valid input after ptr.
  function automatic int pick();
    int w;
    w = int'(weights_i[3'(m_ptr)]);
    if (w == 0) w = 1;
    if (!m_fresh && valid_i[3'(m_ptr)] && m_cnt < w) return m_ptr;
    for (int k = 1; k <= 5; k++) begin
      int j;
      j = (m_ptr + k) % 5;
      if (valid_i[3'(j)]) begin
        m_ptr = j; m_cnt = 0; m_fresh = 1'b0;
        return j;
      end
    end
    return -1;
  endfunction

  task automatic tick();
    logic [4:0] exp_rdy;
    logic [2:0] g;
    bit acc, fire;
    @(negedge ACLK);
    g = 3'(m_grant);
    exp_rdy = '0;
    if (m_busy) exp_rdy[g] = !m_vo || ready_i;
    chk("busy_o", 32'(busy_o), 32'(m_busy));
    if (m_busy) chk("grant_o", 32'(grant_o), 32'(m_grant));
    chk("ready_o", 32'(ready_o), 32'(exp_rdy));
    chk("valid_o", 32'(valid_o), 32'(m_vo));
    if (m_vo && sb_q.size() > 0) chk("out_beat", 32'({last_o, data_o}), 32'(sb_q[0]));
    if (busy_o && !prev_busy) gseq.push_back(int'(grant_o));
    prev_busy = busy_o;
    if (valid_o && ready_i) dseq.push_back({last_o, data_o});
    fire = m_vo && ready_i;
    acc  = m_busy && valid_i[g] && exp_rdy[g];
    if (fire && sb_q.size() > 0) void'(sb_q.pop_front());
    if (acc) begin
      sb_q.push_back({last_i[g], data_i[g]});
      rd[m_grant]++;
    end
    m_vo = acc || (m_vo && !ready_i);
    if (!m_busy) begin
      if (|valid_i) begin
        m_grant = pick();
        m_busy  = 1'b1;
      end
    end else if (acc && last_i[g]) begin
      m_busy = 1'b0;
      if (m_cnt < 15) m_cnt++;
    end
    @(posedge ACLK);
    #1;
    drive();
  endtask

  task automatic apply_reset();
    ARESETn = 1'b0;
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_last_o",  32'(last_o),  32'd0);
    chk("rst_data_o",  32'(data_o),  32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd0);
    chk("rst_busy_o",  32'(busy_o),  32'd0);
    chk("rst_grant_o", 32'(grant_o), 32'd0);
    m_ptr = 4; m_cnt = 0; m_grant = 0;
    m_fresh = 1'b1; m_busy = 1'b0; m_vo = 1'b0;
    sb_q.delete(); gseq.delete(); dseq.delete();
    prev_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin wr[i] = 0; rd[i] = 0; end
    drive();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
  endtask

  task automatic run_drain(input int max, input bit rnd);
    int c;
    c = 0;
    while ((pending() || m_busy || m_vo) && c < max) begin
      if (rnd) begin
        ready_i = ($urandom_range(0, 3) != 0);
        if (c % 25 == 0)
          for (int i = 0; i < 5; i++) weights_i[3'(i)] = 4'($urandom_range(0, 3));
      end
      tick();
      c++;
    end
    ready_i = 1'b1;
    chk("drain_in_time", 32'(c < max), 32'd1);
    tick();
    chk("drain_idle", 32'({busy_o, valid_o}), 32'd0);
  endtask

  task automatic chk_g(input string tag, input int k, input int exp);
    int o;
    o = (k < gseq.size()) ? gseq[k] : -1;
    chk(tag, 32'(o), 32'(exp));
  endtask

  task automatic chk_d(input string tag, input int k, input logic [16:0] exp);
    logic [16:0] o;
    o = 'x;
    if (k < dseq.size()) o = dseq[k];
    chk(tag, 32'(o), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_a[6];
    int          exp_b[8];
    logic [15:0] exp_ad[5];
    ARESETn = 1'b1; ready_i = 1'b1; gap = 1'b0;
    valid_i = '0; last_i = '0; data_i = '0;
    for (int i = 0; i < 5; i++) weights_i[3'(i)] = 4'd1;
    for (int i = 0; i < 5; i++) begin wr[i] = 0; rd[i] = 0; end

    // A: all inputs valid, single-beat packets, weights 1
    apply_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < 5; i++) add_pkt(i, 1, 1'b0);
    drive();
    run_drain(200, 1'b0);
    exp_a  = '{0, 1, 2, 3, 4, 0};
    exp_ad = '{16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    for (int k = 0; k < 6; k++) chk_g("A_grant_seq", k, exp_a[k]);
    for (int k = 0; k < 5; k++) chk_d("A_data_seq", k, {1'b1, exp_ad[k]});

    // B: inputs 2 and 4, weights 3 and 1
    apply_reset();
    weights_i[2] = 4'd3; weights_i[4] = 4'd1;
    for (int r = 0; r < 10; r++) begin add_pkt(2, 1, 1'b0); add_pkt(4, 1, 1'b0); end
    drive();
    run_drain(200, 1'b0);
    exp_b = '{2, 2, 2, 4, 2, 2, 2, 4};
    for (int k = 0; k < 8; k++) chk_g("B_grant_seq", k, exp_b[k]);

    // C: weight 0 behaves as 1
    apply_reset();
    for (int i = 0; i < 5; i++) weights_i[3'(i)] = 4'd1;
    weights_i[0] = 4'd0;
    for (int r = 0; r < 4; r++) begin add_pkt(0, 1, 1'b0); add_pkt(1, 1, 1'b0); end
    drive();
    run_drain(200, 1'b0);
    for (int k = 0; k < 4; k++) chk_g("C_grant_seq", k, k % 2);

    // D: 4-beat packet on input 1 is not interleaved with input 0
    apply_reset();
    for (int i = 0; i < 5; i++) weights_i[3'(i)] = 4'd1;
    add_pkt(1, 4, 1'b0);
    drive();
    tick(); tick();
    for (int r = 0; r < 5; r++) add_pkt(0, 1, 1'b0);
    drive();
    run_drain(200, 1'b0);
    for (int k = 0; k < 4; k++) chk_d("D_pkt_beat", k, {(k == 3), 16'hDDDD});
    chk_d("D_next_beat", 4, {1'b1, 16'hEEEE});
    chk_g("D_grant_first", 0, 1);
    chk_g("D_grant_second", 1, 0);

    // E: downstream stall mid-packet
    apply_reset();
    add_pkt(1, 4, 1'b0);
    drive();
    tick(); tick(); tick();
    ready_i = 1'b0;
    for (int s = 0; s < 5; s++) tick();
    chk("E_stall_ready", 32'(ready_o), 32'd0);
    chk("E_stall_valid", 32'(valid_o), 32'd1);
    ready_i = 1'b1;
    run_drain(200, 1'b0);
    chk("E_beat_count", 32'(dseq.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk_d("E_pkt_beat", k, {(k == 3), 16'hDDDD});

    // F: reset in the middle of a packet
    apply_reset();
    add_pkt(1, 4, 1'b0);
    drive();
    tick(); tick(); tick();
    #2;
    apply_reset();
    add_pkt(3, 1, 1'b0);
    add_pkt(1, 1, 1'b0);
    drive();
    run_drain(200, 1'b0);
    chk_g("F_first_grant", 0, 1);
    chk_g("F_second_grant", 1, 3);

    // G: randomized traffic, weights, gaps and backpressure
    apply_reset();
    gap = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int np;
      np = $urandom_range(0, 12);
      for (int p = 0; p < np; p++) add_pkt(i, $urandom_range(1, 4), 1'b1);
    end
    drive();
    run_drain(5000, 1'b1);
    chk("G_scoreboard_empty", 32'(sb_q.size()), 32'd0);
    gap = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
